// File: rtl/wall_follow_ctrl.sv
// Wall-following controller: debounced front/left/right sensors drive a Moore FSM
// that follows the selected wall, holds timed turns and flags repeated blocked turns.

module wf_debounce #(
  parameter int D = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  logic [CW-1:0] cnt;

  // cnt tracks consecutive samples that disagree with the filtered level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(D - 1)) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end
endmodule

module wall_follow_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int TURN_CYCLES     = 4,
  parameter int STUCK_LIMIT     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       side_sel,
  input  logic       front_sensor,
  input  logic       left_sensor,
  input  logic       right_sensor,
  output logic       front,
  output logic       turn,
  output logic       turn_dir,
  output logic       stuck,
  output logic [2:0] state
);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam int SW = $clog2(STUCK_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    FWD    = 3'd2,
    TURN_A = 3'd3,
    TURN_T = 3'd4,
    STUCK  = 3'd5
  } state_t;

  state_t        st, st_nxt, dec_st;
  logic [TW-1:0] tc, tc_nxt;
  logic [SW-1:0] sc, sc_nxt, dec_sc, sc_inc;
  logic          side_lat;
  logic [2:0]    raw, filt;
  logic          front_f, wall_f, limit_hit;

  assign raw = {right_sensor, left_sensor, front_sensor};

  wf_debounce #(.D(DEBOUNCE_CYCLES)) u_db [2:0] (
    .clk  (clk),
    .reset(reset),
    .raw  (raw),
    .filt (filt)
  );

  assign front_f = filt[0];
  assign wall_f  = side_lat ? filt[2] : filt[1];

  // Stuck counter saturates at the limit; the limit check uses the incremented value
  assign limit_hit = (int'(sc) + 1) >= STUCK_LIMIT;
  assign sc_inc    = limit_hit ? SW'(STUCK_LIMIT) : sc + SW'(1);

  always_comb begin
    dec_st = FWD;
    dec_sc = '0;
    if (front_f) begin
      dec_st = limit_hit ? STUCK : TURN_A;
      dec_sc = sc_inc;
    end else if (!wall_f) begin
      dec_st = TURN_T;
      dec_sc = sc;
    end
  end

  always_comb begin
    st_nxt = st;
    tc_nxt = tc;
    sc_nxt = sc;
    case (st)
      IDLE: begin
        st_nxt = DECIDE;
        tc_nxt = '0;
        sc_nxt = '0;
      end
      DECIDE: begin
        st_nxt = dec_st;
        sc_nxt = dec_sc;
        tc_nxt = '0;
      end
      FWD: begin
        if (front_f || !wall_f) begin
          st_nxt = dec_st;
          sc_nxt = dec_sc;
          tc_nxt = '0;
        end
      end
      TURN_A, TURN_T: begin
        if (tc == TW'(TURN_CYCLES - 1)) begin
          st_nxt = DECIDE;
          tc_nxt = '0;
        end else begin
          tc_nxt = tc + TW'(1);
        end
      end
      STUCK:   st_nxt = STUCK;
      default: st_nxt = IDLE;
    endcase
    if (!enable) begin
      st_nxt = IDLE;
      tc_nxt = '0;
      sc_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      tc       <= '0;
      sc       <= '0;
      side_lat <= 1'b0;
    end else begin
      st <= st_nxt;
      tc <= tc_nxt;
      sc <= sc_nxt;
      if (st == IDLE && enable) side_lat <= side_sel;
    end
  end

  assign front    = (st == FWD);
  assign turn     = (st == TURN_A) || (st == TURN_T);
  assign turn_dir = (st == TURN_A) ? ~side_lat : (st == TURN_T) ? side_lat : 1'b0;
  assign stuck    = (st == STUCK);
  assign state    = st;
endmodule
